// File: rtl/rr_decode_arbiter.sv
// Eight-way round-robin arbiter with registered index, one-hot grant and decoder enable.
// Grants are held until done, request drop, or the HOLD_MAX limit, then one dead RELEASE cycle.
module rr_decode_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_i,
    input  logic       done_i,
    output logic       gnt_en_o,
    output logic [2:0] gnt_idx_o,
    output logic [7:0] gnt_o,
    output logic       busy_o,
    output logic       timeout_o
);

    localparam int HW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [2:0]    idx_q, idx_d;
    logic          en_q, en_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          tmo_q, tmo_d;

    logic          pick_found;
    logic [2:0]    pick_idx;
    logic          limit_hit;
    logic          release_now;

    // First requester at or after ptr_q; 3-bit addition wraps the search naturally.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!pick_found && req_i[ptr_q + 3'(i)]) begin
                pick_found = 1'b1;
                pick_idx   = ptr_q + 3'(i);
            end
        end
    end

    assign limit_hit   = (HOLD_MAX != 0) && (hold_q == HW'(HOLD_MAX - 1));
    assign release_now = done_i || !req_i[idx_q] || limit_hit;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        en_d    = en_q;
        hold_d  = hold_q;
        tmo_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    idx_d   = pick_idx;
                    en_d    = 1'b1;
                    hold_d  = '0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (release_now) begin
                    // Timeout only when the limit is the sole reason for releasing.
                    tmo_d   = !done_i && req_i[idx_q];
                    en_d    = 1'b0;
                    idx_d   = '0;
                    ptr_d   = idx_q + 3'd1;
                    state_d = S_RELEASE;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            en_q    <= 1'b0;
            hold_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
        end
    end

    assign gnt_en_o  = en_q;
    assign gnt_idx_o = idx_q;
    assign gnt_o     = en_q ? (8'd1 << idx_q) : '0;
    assign busy_o    = (state_q != S_IDLE);
    assign timeout_o = tmo_q;

endmodule
